// File: rtl/ipv4_tx.sv
// IPv4/Ethernet transmit framer: prepends Ethernet II and IPv4 (UDP) headers to an upstream
// datagram stream and emits 32-bit words with sop/eop/byte-count to the MAC TX interface.
module ipv4_tx #(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter int unsigned MAX_LEN = 1480
) (
  input  logic        clk_user_i,
  input  logic        reset_i,
  input  logic        tx_start_i,
  input  logic [15:0] tx_len_i,
  input  logic [47:0] tx_dst_mac_i,
  input  logic [31:0] tx_dst_ip_i,
  input  logic [47:0] our_mac_i,
  input  logic [31:0] our_ip_i,
  output logic        tx_busy_o,
  input  logic        tx_udp_data_vld_i,
  input  logic [31:0] tx_udp_data_i,
  input  logic [3:0]  tx_udp_data_be_i,
  input  logic        tx_udp_data_tlast_i,
  output logic        tx_udp_data_rd_o,
  output logic        tx_mac_data_vld_o,
  output logic [31:0] tx_mac_data_o,
  output logic        tx_mac_data_sop_o,
  output logic        tx_mac_data_eop_o,
  output logic [1:0]  tx_mac_data_be_o,
  input  logic        tx_mac_data_ready_i
);

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StCsum, StHdr, StData, StTail} state_e;
  state_e state_q, state_d;

  logic [15:0] len_q, ident_q, prev_q;
  logic [47:0] dst_mac_q;
  logic [31:0] dst_ip_q, csum_q, tail_data_q;
  logic [2:0]  cnt_q;
  logic [1:0]  tail_be_q;
  logic        tail_pend_q, busy_q;

  logic        out_vld_q, out_sop_q, out_eop_q;
  logic [31:0] out_data_q;
  logic [1:0]  out_be_q;
  logic        out_vld_d, out_sop_d, out_eop_d;
  logic [31:0] out_data_d;
  logic [1:0]  out_be_d;

  logic        start_ok, can_load, eop_acc, rd, up_acc, up_last;
  logic [15:0] total_len, fold_sum;
  logic [31:0] hdr_sum, hdr_word;
  logic [2:0]  hdr_idx;

  assign total_len = len_q + 16'd20;
  assign start_ok  = (state_q == StIdle) && tx_start_i &&
                     (tx_len_i >= 16'd8) && (tx_len_i <= MaxLen);
  assign can_load  = !out_vld_q || tx_mac_data_ready_i;
  assign eop_acc   = out_vld_q && out_eop_q && tx_mac_data_ready_i;
  assign rd        = (state_q == StData) && can_load;
  assign up_acc    = tx_udp_data_vld_i && rd;
  assign up_last   = up_acc && tx_udp_data_tlast_i;

  // Ones-complement header sum with the checksum field taken as zero.
  assign hdr_sum = 32'h4500 + 32'(total_len) + 32'(ident_q) + 32'h4000 +
                   32'({TTL, 8'd17}) + 32'(our_ip_i[31:16]) + 32'(our_ip_i[15:0]) +
                   32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0]);
  assign fold_sum = csum_q[15:0] + csum_q[31:16];

  // w0 is loaded on the last checksum cycle, before cnt_q becomes the header index.
  assign hdr_idx = (state_q == StHdr) ? cnt_q : 3'd0;

  always_comb begin
    case (hdr_idx)
      3'd0:    hdr_word = dst_mac_q[47:16];
      3'd1:    hdr_word = {dst_mac_q[15:0], our_mac_i[47:32]};
      3'd2:    hdr_word = our_mac_i[31:0];
      3'd3:    hdr_word = 32'h0800_4500;
      3'd4:    hdr_word = {total_len, ident_q};
      3'd5:    hdr_word = {16'h4000, TTL, 8'd17};
      3'd6:    hdr_word = {csum_q[15:0], our_ip_i[31:16]};
      default: hdr_word = {our_ip_i[15:0], dst_ip_q[31:16]};
    endcase
  end

  always_ff @(posedge clk_user_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = StCsum;
      StCsum: if (cnt_q == 3'd2) state_d = StHdr;
      StHdr:  if (can_load && cnt_q == 3'd7) state_d = StData;
      StData: if (up_last) state_d = StTail;
      StTail: if (!tail_pend_q && eop_acc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_be_d   = out_be_q;
    if (can_load) begin
      out_vld_d  = 1'b0;
      out_data_d = '0;
      out_sop_d  = 1'b0;
      out_eop_d  = 1'b0;
      out_be_d   = 2'b00;
    end
    unique case (state_q)
      StCsum: begin
        if (cnt_q == 3'd2) begin
          out_vld_d  = 1'b1;
          out_data_d = hdr_word;
          out_sop_d  = 1'b1;
        end
      end
      StHdr: begin
        if (can_load) begin
          out_vld_d  = 1'b1;
          out_data_d = hdr_word;
        end
      end
      StData: begin
        if (up_acc) begin
          out_vld_d  = 1'b1;
          out_data_d = {prev_q, tx_udp_data_i[31:16]};
          if (tx_udp_data_tlast_i) begin
            case (tx_udp_data_be_i)
              4'b1000: begin
                out_data_d = {prev_q, tx_udp_data_i[31:24], 8'h00};
                out_eop_d  = 1'b1;
                out_be_d   = 2'b11;
              end
              4'b1100: out_eop_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      StTail: begin
        if (can_load && tail_pend_q) begin
          out_vld_d  = 1'b1;
          out_data_d = tail_data_q;
          out_eop_d  = 1'b1;
          out_be_d   = tail_be_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      len_q       <= '0;
      dst_mac_q   <= '0;
      dst_ip_q    <= '0;
      ident_q     <= '0;
      prev_q      <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
      tail_data_q <= '0;
      tail_be_q   <= '0;
      tail_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_be_q    <= '0;
    end else begin
      busy_q     <= (state_d != StIdle);
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_be_q   <= out_be_d;
      if (eop_acc) ident_q <= ident_q + 16'd1;
      if (start_ok) begin
        len_q     <= tx_len_i;
        dst_mac_q <= tx_dst_mac_i;
        dst_ip_q  <= tx_dst_ip_i;
        prev_q    <= tx_dst_ip_i[15:0];
        cnt_q     <= 3'd0;
      end
      if (state_q == StCsum) begin
        cnt_q <= (cnt_q == 3'd2) ? 3'd1 : cnt_q + 3'd1;
        case (cnt_q)
          3'd0:    csum_q <= hdr_sum;
          3'd1:    csum_q <= 32'(csum_q[15:0]) + 32'(csum_q[31:16]);
          default: csum_q <= {16'h0000, ~fold_sum};
        endcase
      end
      if (state_q == StHdr && can_load) cnt_q <= cnt_q + 3'd1;
      if (up_acc) prev_q <= tx_udp_data_i[15:0];
      // Three or four bytes in the last word spill into an extra tail word.
      if (up_last) begin
        tail_pend_q <= tx_udp_data_be_i[1];
        tail_data_q <= tx_udp_data_be_i[0] ? {tx_udp_data_i[15:0], 16'h0000}
                                           : {tx_udp_data_i[15:8], 24'h000000};
        tail_be_q   <= tx_udp_data_be_i[0] ? 2'b10 : 2'b01;
      end
      if (state_q == StTail && tail_pend_q && can_load) tail_pend_q <= 1'b0;
    end
  end

  assign tx_busy_o         = busy_q;
  assign tx_udp_data_rd_o  = rd;
  assign tx_mac_data_vld_o = out_vld_q;
  assign tx_mac_data_o     = out_data_q;
  assign tx_mac_data_sop_o = out_sop_q;
  assign tx_mac_data_eop_o = out_eop_q;
  assign tx_mac_data_be_o  = out_be_q;

endmodule
